// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM/IO port between instruction fetch
// (4-byte reads) and the store/load buffer (1/2/4-byte loads and stores).
// Accesses are serialised into byte transactions; read bytes are assembled
// little-endian. A one-cycle completion pulse goes back to the requester.
// Optional feature macro: MEM_ARB_IO_STALL_EN (stall IO-space store bytes
// while io_buffer_full is high).
module mem_arbiter #(
    parameter int         NICK_W     = 4,
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iIF_en,
    input  logic [31:0]       iIF_addr,
    output logic              oIF_en,
    output logic [31:0]       oIF_dt,
    input  logic              iSLB_en,
    input  logic              iSLB_ls,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [2:0]        iSLB_len,
    input  logic              iSLB_sext,
    input  logic [31:0]       iSLB_addr,
    input  logic [31:0]       iSLB_dt,
    output logic              oSLB_en,
    output logic [NICK_W-1:0] oSLB_nick,
    output logic [31:0]       oSLB_dt,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic LG_IF  = 1'b0;
    localparam logic LG_SLB = 1'b1;

    state_t              state_reg, state_next;
    logic [2:0]          cnt_reg;
    logic [2:0]          len_reg;
    logic                owner_if_reg;
    logic                sext_reg;
    logic [NICK_W-1:0]   nick_reg;
    logic                last_grant_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         mem_a_reg;
    logic [7:0]          mem_dout_reg;
    logic                mem_wr_reg;
    logic                if_en_reg, slb_en_reg;
    logic [31:0]         if_dt_reg, slb_dt_reg;
    logic [NICK_W-1:0]   slb_nick_reg;

    logic                grant_if, grant_slb;
    logic                rd_step, rd_done, wr_adv, wr_done;
    logic                io_stall;
    logic [2:0]          slb_len;
    logic [31:0]         rd_word;
    logic                sign_bit;

`ifdef MEM_ARB_IO_STALL_EN
    // An IO-space store byte waits while the IO write buffer is full.
    assign io_stall = (state_reg == WRITE) && mem_wr_reg &&
                      (mem_a_reg[17:16] == IO_BASE_HI) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    // Only 1 and 2 are honoured as short lengths; anything else is a word.
    always_comb begin
        case (iSLB_len)
            3'd1:    slb_len = 3'd1;
            3'd2:    slb_len = 3'd2;
            default: slb_len = 3'd4;
        endcase
    end

    // Next-state logic, arbitration and per-edge control strobes.
    always_comb begin
        state_next = state_reg;
        grant_if   = 1'b0;
        grant_slb  = 1'b0;
        rd_step    = 1'b0;
        rd_done    = 1'b0;
        wr_adv     = 1'b0;
        wr_done    = 1'b0;
        if (rdy) begin
            case (state_reg)
                IDLE: begin
                    if (!clr) begin
                        if (iIF_en && (!iSLB_en || last_grant_reg == LG_SLB)) begin
                            grant_if   = 1'b1;
                            state_next = READ;
                        end else if (iSLB_en) begin
                            grant_slb  = 1'b1;
                            state_next = iSLB_ls ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    if (clr) begin
                        state_next = IDLE;
                    end else if (cnt_reg == len_reg) begin
                        rd_done    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rd_step = 1'b1;
                    end
                end
                WRITE: begin
                    // A committed store ignores clr and always finishes.
                    if (!io_stall) begin
                        if (cnt_reg == len_reg - 3'd1) begin
                            wr_done    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            wr_adv = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Per-lane read byte capture: byte i arrives two edges after it is addressed.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (!rst)
                    byte_reg <= 8'h00;
                else if (rdy && state_reg == READ && cnt_reg == 3'(gi + 1))
                    byte_reg <= mem_din;
            end
            // Final byte comes straight from mem_din; lanes above len are extension.
            assign rd_word[8*gi +: 8] = (3'(gi + 1) == len_reg) ? mem_din :
                                        (3'(gi + 1) <  len_reg) ? byte_reg :
                                        {8{sign_bit}};
        end
    endgenerate

    // The final byte is the most significant one, so it supplies the sign.
    assign sign_bit = sext_reg & mem_din[7];

    // Request latching, address/data sequencing and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg        <= 3'd0;
            len_reg        <= 3'd4;
            owner_if_reg   <= 1'b0;
            sext_reg       <= 1'b0;
            nick_reg       <= '0;
            last_grant_reg <= LG_IF;
            wdata_reg      <= 32'h0;
            mem_a_reg      <= 32'h0;
            mem_dout_reg   <= 8'h00;
            mem_wr_reg     <= 1'b0;
            if_en_reg      <= 1'b0;
            if_dt_reg      <= 32'h0;
            slb_en_reg     <= 1'b0;
            slb_dt_reg     <= 32'h0;
            slb_nick_reg   <= '0;
        end else if (rdy) begin
            if_en_reg  <= 1'b0;
            slb_en_reg <= 1'b0;
            if (grant_if) begin
                last_grant_reg <= LG_IF;
                owner_if_reg   <= 1'b1;
                len_reg        <= 3'd4;
                sext_reg       <= 1'b0;
                cnt_reg        <= 3'd0;
                mem_a_reg      <= iIF_addr;
            end
            if (grant_slb) begin
                last_grant_reg <= LG_SLB;
                owner_if_reg   <= 1'b0;
                len_reg        <= slb_len;
                sext_reg       <= iSLB_sext;
                nick_reg       <= iSLB_nick;
                cnt_reg        <= 3'd0;
                mem_a_reg      <= iSLB_addr;
                wdata_reg      <= iSLB_dt;
                mem_dout_reg   <= iSLB_dt[7:0];
                mem_wr_reg     <= iSLB_ls;
            end
            if (rd_step) begin
                cnt_reg <= cnt_reg + 3'd1;
                if (cnt_reg + 3'd1 < len_reg)
                    mem_a_reg <= mem_a_reg + 32'd1;
            end
            if (rd_done) begin
                if (owner_if_reg) begin
                    if_en_reg <= 1'b1;
                    if_dt_reg <= rd_word;
                end else begin
                    slb_en_reg   <= 1'b1;
                    slb_dt_reg   <= rd_word;
                    slb_nick_reg <= nick_reg;
                end
            end
            if (wr_adv) begin
                cnt_reg      <= cnt_reg + 3'd1;
                mem_a_reg    <= mem_a_reg + 32'd1;
                mem_dout_reg <= wdata_reg[15:8];
                wdata_reg    <= wdata_reg >> 8;
            end
            if (wr_done) begin
                mem_wr_reg   <= 1'b0;
                slb_en_reg   <= 1'b1;
                slb_dt_reg   <= 32'h0;
                slb_nick_reg <= nick_reg;
            end
        end
    end

    assign oIF_en    = if_en_reg;
    assign oIF_dt    = if_dt_reg;
    assign oSLB_en   = slb_en_reg;
    assign oSLB_dt   = slb_dt_reg;
    assign oSLB_nick = slb_nick_reg;
    assign mem_a     = mem_a_reg;
    assign mem_dout  = mem_dout_reg;
    // Writes are suppressed while frozen or stalled; the byte re-issues afterwards.
    assign mem_wr    = mem_wr_reg & rdy & ~io_stall;

endmodule
